// File: rtl/riscv_pkg.sv
// Shared RV32I definitions used by the fetch and decode stages.
package riscv_pkg;

    // Canonical NOP (addi x0, x0, 0) presented to decode when nothing is buffered
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Major opcodes, shared with decode
    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_SB    = 7'b1100011;
    localparam logic [6:0] OPC_LW    = 7'b0000011;
    localparam logic [6:0] OPC_SW    = 7'b0100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    // Fetch engine states
    typedef enum logic [1:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_DISCARD
    } fetch_state_e;

    // One buffered fetch: instruction word tagged with its address
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head is read straight from the storage registers.
module fetch_fifo #(
    parameter  int unsigned DEPTH = 2,
    parameter  int unsigned WIDTH = 64,
    localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    // Accept a pop only when data exists; a push into a full FIFO needs a pop
    always_comb begin
        do_pop  = pop_i && (count_q != '0);
        do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    end

    // Pointer/count next state; flush wins over push and pop
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are don't-care while empty so no reset is needed
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// RV32I instruction fetch stage: PC ownership, single-outstanding imem
// handshake, instruction buffer, and redirect/squash handling.
module instr_fetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] Instruction,
    output logic [31:0] PC
);

    localparam int unsigned CW   = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCCW = CW + 1;

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_addr_q, req_addr_d;
    // Set while a REQ is still pending but a redirect already made it stale
    logic          stale_q, stale_d;

    logic          fifo_push, fifo_pop, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  fifo_head, fifo_wdata;
    logic [OCCW-1:0] occ_next;
    logic          issue_ok;

    // Buffer handshake and issue rule: only issue if the in-flight word has a slot
    always_comb begin
        fifo_push       = (state_q == FS_WAIT) && imem_rvalid && !redirect_valid;
        id_valid        = !fifo_empty && !redirect_valid;
        fifo_pop        = id_valid && id_ready;
        fifo_wdata.instr = imem_rdata;
        fifo_wdata.pc    = req_addr_q;
        occ_next        = OCCW'(fifo_count) + OCCW'(fifo_push) - OCCW'(fifo_pop);
        issue_ok        = !redirect_valid && (occ_next < OCCW'(FIFO_DEPTH));
    end

    // Fetch FSM next state, PC update and request address capture
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_addr_d = req_addr_q;
        stale_d    = 1'b0;

        if (redirect_valid) begin
            pc_d = word_align(redirect_pc);
        end

        case (state_q)
            FS_IDLE: begin
                if (redirect_valid || issue_ok) begin
                    state_d = FS_REQ;
                end
            end
            FS_REQ: begin
                if (imem_gnt) begin
                    if (stale_q || redirect_valid) begin
                        state_d = FS_DISCARD;
                    end else begin
                        state_d = FS_WAIT;
                        pc_d    = pc_q + 32'd4;
                    end
                end else begin
                    // The request cannot be withdrawn; remember it is stale
                    stale_d = stale_q || redirect_valid;
                end
            end
            FS_WAIT: begin
                if (redirect_valid) begin
                    state_d = imem_rvalid ? FS_IDLE : FS_DISCARD;
                end else if (imem_rvalid) begin
                    state_d = issue_ok ? FS_REQ : FS_IDLE;
                end
            end
            FS_DISCARD: begin
                if (imem_rvalid) begin
                    state_d = FS_IDLE;
                end
            end
            default: begin
                state_d = FS_IDLE;
            end
        endcase

        // Address is latched on entry to REQ and held until the grant
        if ((state_d == FS_REQ) && (state_q != FS_REQ)) begin
            req_addr_d = pc_d;
        end
    end

    // Fetch engine registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FS_IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            stale_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            stale_q    <= stale_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fetch_entry_t))
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (fifo_push),
        .push_data_i (fifo_wdata),
        .pop_i       (fifo_pop),
        .flush_i     (redirect_valid),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Decode-side and memory-side outputs
    always_comb begin
        imem_req    = (state_q == FS_REQ);
        imem_addr   = req_addr_q;
        Instruction = fifo_empty ? NOP_INSTR : fifo_head.instr;
        PC          = fifo_empty ? '0 : fifo_head.pc;
    end

    // A response is only meaningful while a granted fetch is outstanding
    a_no_stray_rvalid: assert property (@(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> ((state_q == FS_WAIT) || (state_q == FS_DISCARD)));

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam logic [31:0] TAG  = 32'hDEAD_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] RPC  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] Instruction;
    logic [31:0] PC;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Memory model: grant whenever enabled, respond one cycle after grant
    logic        gnt_en = 1'b1;
    logic        rvalid_en = 1'b1;
    logic        pend_q = 1'b0;
    logic [31:0] pend_addr_q = '0;

    assign imem_gnt    = imem_req && gnt_en;
    assign imem_rvalid = pend_q && rvalid_en;
    assign imem_rdata  = pend_addr_q ^ TAG;

    always @(posedge clk) begin
        if (imem_req && imem_gnt) begin
            pend_q      <= 1'b1;
            pend_addr_q <= imem_addr;
        end else if (imem_rvalid) begin
            pend_q <= 1'b0;
        end
    end

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(RPC), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .Instruction    (Instruction),
        .PC             (PC)
    );

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        id_ready       = 1'b1;
        gnt_en         = 1'b1;
        rvalid_en      = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_req(input logic [31:0] addr, input int unsigned budget, output bit found);
        found = 1'b0;
        for (int unsigned i = 0; i < budget; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == addr) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        vectors += 5;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_imem_req: got %0b expected 0", imem_req); end
        if (imem_addr !== RPC) begin errors++; $display("FAIL reset_imem_addr: got %h expected %h", imem_addr, RPC); end
        if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %0b expected 0", id_valid); end
        if (Instruction !== NOP) begin errors++; $display("FAIL reset_instr: got %h expected %h", Instruction, NOP); end
        if (PC !== 32'h0) begin errors++; $display("FAIL reset_pc: got %h expected 0", PC); end
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        int unsigned got;
        do_reset();
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if (id_valid !== (i == 2)) begin errors++; $display("FAIL stream_first_valid c%0d: got %0b expected %0b", i, id_valid, (i == 2)); end
            if (i == 0) begin
                vectors += 2;
                if (imem_req !== 1'b1) begin errors++; $display("FAIL stream_first_req: got %0b expected 1", imem_req); end
                if (imem_addr !== RPC) begin errors++; $display("FAIL stream_first_addr: got %h expected %h", imem_addr, RPC); end
            end
        end
        exp_pc = RPC;
        got = 0;
        for (int unsigned c = 0; c < 40 && got < 8; c++) begin
            if (c != 0) @(negedge clk);
            if (id_valid) begin
                vectors += 2;
                if (PC !== exp_pc) begin errors++; $display("FAIL stream_pc: got %h expected %h", PC, exp_pc); end
                if (Instruction !== (exp_pc ^ TAG)) begin errors++; $display("FAIL stream_instr: got %h expected %h", Instruction, exp_pc ^ TAG); end
                exp_pc += 32'd4;
                got++;
            end
        end
        vectors++;
        if (got != 8) begin errors++; $display("FAIL stream_count: got %0d expected 8", got); end
    endtask

    task automatic test_stall();
        bit found;
        logic [31:0] exp_pc;
        int unsigned got;
        do_reset();
        found = 1'b0;
        for (int unsigned c = 0; c < 30; c++) begin
            @(negedge clk);
            if (id_valid && PC == 32'h8) begin found = 1'b1; break; end
        end
        vectors++;
        if (!found) begin errors++; $display("FAIL stall_reach_8: got none expected PC 8 presented"); end
        id_ready = 1'b0;
        for (int unsigned c = 0; c < 10; c++) begin
            @(negedge clk);
            vectors++;
            if (!(id_valid === 1'b1 && PC === 32'h8)) begin errors++; $display("FAIL stall_hold: got v=%0b pc=%h expected v=1 pc=8", id_valid, PC); end
        end
        vectors += 2;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL stall_req_low: got %0b expected 0", imem_req); end
        if (dut.u_fifo.count_o !== 2'd2) begin errors++; $display("FAIL stall_fifo_full: got %0d expected 2", dut.u_fifo.count_o); end
        id_ready = 1'b1;
        exp_pc = 32'h8;
        got = 0;
        for (int unsigned c = 0; c < 20 && got < 3; c++) begin
            if (c != 0) @(negedge clk);
            if (id_valid) begin
                vectors++;
                if (PC !== exp_pc) begin errors++; $display("FAIL stall_release_pc: got %h expected %h", PC, exp_pc); end
                exp_pc += 32'd4;
                got++;
            end
        end
        vectors++;
        if (got != 3) begin errors++; $display("FAIL stall_release_count: got %0d expected 3", got); end
    endtask

    // After a redirect: first request address, first presented PC, and no forbidden PC
    task automatic observe_after_redirect(input logic [31:0] target, input logic [31:0] bad_pc, input string name);
        bit seen_req, seen_pc, bad;
        logic [31:0] first_req, first_pc, first_ins;
        seen_req = 1'b0; seen_pc = 1'b0; bad = 1'b0;
        first_req = '0; first_pc = '0; first_ins = '0;
        for (int unsigned c = 0; c < 20; c++) begin
            @(negedge clk);
            if (imem_req && !seen_req) begin seen_req = 1'b1; first_req = imem_addr; end
            if (id_valid && !seen_pc) begin seen_pc = 1'b1; first_pc = PC; first_ins = Instruction; end
            if (id_valid && PC == bad_pc) bad = 1'b1;
            if (imem_req && imem_addr == bad_pc) bad = 1'b1;
        end
        vectors += 4;
        if (!(seen_req && first_req === target)) begin errors++; $display("FAIL %s_next_req: got %h expected %h", name, first_req, target); end
        if (!(seen_pc && first_pc === target)) begin errors++; $display("FAIL %s_first_pc: got %h expected %h", name, first_pc, target); end
        if (first_ins !== (target ^ TAG)) begin errors++; $display("FAIL %s_first_instr: got %h expected %h", name, first_ins, target ^ TAG); end
        if (bad) begin errors++; $display("FAIL %s_stale_seen: got PC/addr %h observed expected never", name, bad_pc); end
    endtask

    task automatic test_redirect_wait();
        bit found;
        do_reset();
        wait_req(32'h10, 40, found);
        vectors++;
        if (!found) begin errors++; $display("FAIL rwait_reach: got no req expected req to 10"); end
        rvalid_en = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        #1;
        vectors++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL rwait_valid_gated: got %0b expected 0", id_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        rvalid_en      = 1'b1;
        observe_after_redirect(32'h100, 32'h10, "rwait");
    endtask

    task automatic test_redirect_req();
        bit found;
        do_reset();
        wait_req(32'h8, 40, found);
        vectors++;
        if (!found) begin errors++; $display("FAIL rreq_reach: got no req expected req to 8"); end
        gnt_en         = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int unsigned c = 0; c < 3; c++) begin
            vectors += 2;
            if (imem_req !== 1'b1) begin errors++; $display("FAIL rreq_hold_req: got %0b expected 1", imem_req); end
            if (imem_addr !== 32'h8) begin errors++; $display("FAIL rreq_hold_addr: got %h expected 8", imem_addr); end
            if (c != 2) @(negedge clk);
        end
        gnt_en = 1'b1;
        observe_after_redirect(32'h200, 32'hFFFF_FFF0, "rreq");
    endtask

    task automatic test_back_to_back();
        bit found;
        do_reset();
        wait_req(32'h8, 40, found);
        vectors++;
        if (!found) begin errors++; $display("FAIL b2b_reach: got no req expected req to 8"); end
        rvalid_en = 1'b0;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        @(negedge clk);
        redirect_pc    = 32'h400;
        @(negedge clk);
        redirect_valid = 1'b0;
        rvalid_en      = 1'b1;
        observe_after_redirect(32'h400, 32'h300, "b2b");
    endtask

    task automatic test_reset_mid_wait();
        bit found, seen;
        logic [31:0] first_pc;
        do_reset();
        wait_req(32'h4, 40, found);
        vectors++;
        if (!found) begin errors++; $display("FAIL rmid_reach: got no req expected req to 4"); end
        rvalid_en = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors += 5;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL rmid_req: got %0b expected 0", imem_req); end
        if (imem_addr !== RPC) begin errors++; $display("FAIL rmid_addr: got %h expected %h", imem_addr, RPC); end
        if (id_valid !== 1'b0) begin errors++; $display("FAIL rmid_valid: got %0b expected 0", id_valid); end
        if (Instruction !== NOP) begin errors++; $display("FAIL rmid_instr: got %h expected %h", Instruction, NOP); end
        if (PC !== 32'h0) begin errors++; $display("FAIL rmid_pc: got %h expected 0", PC); end
        rvalid_en = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        vectors += 2;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL rmid_restart_req: got %0b expected 1", imem_req); end
        if (imem_addr !== RPC) begin errors++; $display("FAIL rmid_restart_addr: got %h expected %h", imem_addr, RPC); end
        seen = 1'b0;
        first_pc = 32'hFFFF_FFFF;
        for (int unsigned c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (id_valid) begin seen = 1'b1; first_pc = PC; end
        end
        vectors++;
        if (first_pc !== RPC) begin errors++; $display("FAIL rmid_first_pc: got %h expected %h", first_pc, RPC); end
    endtask

    task automatic test_wrap_latency();
        bit seen;
        logic [31:0] next_pc;
        do_reset();
        id_ready = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (imem_req !== 1'b0) begin errors++; $display("FAIL wrap_idle: got %0b expected 0", imem_req); end
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        id_ready       = 1'b1;
        #1;
        vectors++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid_gated: got %0b expected 0", id_valid); end
        @(negedge clk);
        redirect_valid = 1'b0;
        vectors += 2;
        if (imem_req !== 1'b1) begin errors++; $display("FAIL wrap_req_t1: got %0b expected 1", imem_req); end
        if (imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr_t1: got %h expected fffffffc", imem_addr); end
        @(negedge clk);
        vectors++;
        if (id_valid !== 1'b0) begin errors++; $display("FAIL wrap_valid_t2: got %0b expected 0", id_valid); end
        @(negedge clk);
        vectors += 3;
        if (id_valid !== 1'b1) begin errors++; $display("FAIL wrap_valid_t3: got %0b expected 1", id_valid); end
        if (PC !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc_t3: got %h expected fffffffc", PC); end
        if (Instruction !== (32'hFFFF_FFFC ^ TAG)) begin errors++; $display("FAIL wrap_instr_t3: got %h expected %h", Instruction, 32'hFFFF_FFFC ^ TAG); end
        seen = 1'b0;
        next_pc = 32'hFFFF_FFFF;
        for (int unsigned c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (id_valid) begin seen = 1'b1; next_pc = PC; end
        end
        vectors++;
        if (next_pc !== 32'h0) begin errors++; $display("FAIL wrap_next_pc: got %h expected 0", next_pc); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_wait();
        test_redirect_req();
        test_back_to_back();
        test_reset_mid_wait();
        test_wrap_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
